// File: rtl/regfile_wb_arbiter.sv
// Purpose : round-robin arbiter sequencing ALU (A) and load (B) writebacks onto the
//           single register-file write port, with x0 filtering and staged-write forwarding.
// Latency : accepted in cycle t, staged at the posedge ending t, written to the RF one edge later.
// Backpressure: a_ready/b_ready are the grants; none issued while hold=1. The RF never stalls us.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   hold                  control stall, blocks all grants
//   a_* / b_*             requester valid/ready handshakes with destination rd and data
//   rf_we/rf_rd/rf_indata staged write driving the RF write port
//   rs1/rs2, rf_rv1/rf_rv2 read addresses and raw RF read data
//   rv1/rv2               read data with x0 and staged-write forwarding applied
//   wr_count/drop_count   committed-write and dropped-x0-write counters (wrapping)
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_indata,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] rf_rv1,
  input  logic [XLEN-1:0] rf_rv2,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  output logic [CW-1:0]   wr_count,
  output logic [CW-1:0]   drop_count
);

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_e;

  last_e            last_grant;
  logic             grant_a;
  logic             grant_b;
  logic             handshake;
  logic [AW-1:0]    win_rd;
  logic [XLEN-1:0]  win_data;

  // Round-robin: a lone requester always wins; on contention the one that
  // did not win last time is served.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!hold) begin
      if (a_valid && b_valid) begin
        if (last_grant == LAST_B) grant_a = 1'b1;
        else                      grant_b = 1'b1;
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign handshake = (a_valid && grant_a) || (b_valid && grant_b);
  assign win_rd    = grant_a ? a_rd   : b_rd;
  assign win_data  = grant_a ? a_data : b_data;

  // One-entry staging register. rf_we is a one-cycle pulse per accepted
  // non-x0 write; rf_rd/rf_indata keep their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_indata  <= '0;
      last_grant <= LAST_B;
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      rf_we <= 1'b0;
      if (handshake) begin
        last_grant <= grant_b ? LAST_B : LAST_A;
        if (win_rd != '0) begin
          rf_we     <= 1'b1;
          rf_rd     <= win_rd;
          rf_indata <= win_data;
          wr_count  <= wr_count + CW'(1);
        end else begin
          // x0 writes complete the handshake but never reach the RF.
          drop_count <= drop_count + CW'(1);
        end
      end
    end
  end

  // Only the staged entry is forwarded; requests still in arbitration are
  // invisible to readers until they are staged.
  always_comb begin
    rv1 = rf_rv1;
    if (rs1 == '0)                       rv1 = '0;
    else if (rf_we && (rf_rd == rs1))    rv1 = rf_indata;
  end

  always_comb begin
    rv2 = rf_rv2;
    if (rs2 == '0)                       rv2 = '0;
    else if (rf_we && (rf_rd == rs2))    rv2 = rf_indata;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Sequences the single write port of the 32x32 register file (RF: rs1/rs2/rd/we/indata/rv1/rv2) between two writeback requesters, A (ALU) and B (load unit).
- Arbitrates round-robin with valid/ready handshakes and stages the winning write in a one-entry output register that drives the RF write port.
- Forwards the staged write onto the read path, so reads issued during the staging cycle see the new value.
- Enforces x0 semantics: writes to register 0 are dropped and reads of register 0 return 0.

Parameters:
- XLEN, 32, data width
- AW, 5, register address width (2^AW registers)
- CW, 16, width of the committed-write and dropped-write counters

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  stall from control; while 1, no grants are issued
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  A's write accepted this cycle
- a_rd  in  AW  A destination register
- a_data  in  XLEN  A write data
- b_valid, b_ready, b_rd, b_data  as for A, requester B
- rf_we  out  1  to RF we
- rf_rd  out  AW  to RF rd
- rf_indata  out  XLEN  to RF indata
- rs1, rs2  in  AW  read addresses, passed through to the RF
- rf_rv1, rf_rv2  in  XLEN  raw RF read data
- rv1, rv2  out  XLEN  forwarded read data to the datapath
- wr_count  out  CW  number of committed RF writes
- drop_count  out  CW  number of accepted writes to x0

Behaviour:
Reset (asynchronous, on rst_n=0):
- rf_we=0, rf_rd=0, rf_indata=0, last_grant=B (so A wins first), wr_count=0, drop_count=0.
- Reset asserted mid-operation discards any staged write; the RF must not be written on a clock edge while rst_n=0.

Arbitration (combinational in cycle t):
- hold=1: a_ready=b_ready=0.
- Only one requester valid: that requester is granted.
- Both valid: grant the requester that is not last_grant.
- a_ready/b_ready equal the grant; at most one is high per cycle.
- A handshake occurs when valid&&ready.
- valid must stay high with rd/data stable until ready; the arbiter never waits for RF backpressure.

Staging (posedge ending cycle t):
- On a handshake with rd!=0: rf_we<=1, rf_rd<=rd, rf_indata<=data, wr_count<=wr_count+1.
- On a handshake with rd==0: rf_we<=0, drop_count<=drop_count+1. The handshake still completes.
- No handshake: rf_we<=0; rf_rd and rf_indata hold their previous values.
- On any handshake, last_grant<=granted requester.
- Latency: accepted in cycle t, written to the RF at the posedge ending cycle t+1. Back-to-back writes run at 1 per cycle.
- Both counters wrap modulo 2^CW without saturating.

Forwarding (combinational, per read port, rs1 shown; rs2 identical):
- rs1==0: rv1=0.
- else if rf_we && rf_rd==rs1: rv1=rf_indata.
- else: rv1=rf_rv1.
- Forwarding looks only at the staged entry, not at requests still in arbitration.

Simultaneous events:
- A and B request the same rd in consecutive grants: both commit in grant order, and the later write wins.
- Reads forward only the staged (older) write.

Test Plan:
- Reset then A-only writes: A writes rd=i, data=i+100 for i=1..31 with B idle. Required: a_ready=1 every cycle; rf_we with rd=i and indata=i+100 one cycle later; wr_count=31; reading rs1=i, rs2=i returns rv1=rv2=i+100.
- Both valid for 8 cycles: A rd=3, B rd=4. Required: grants alternate A,B,A,B…, starting with A after reset; 4 grants each; wr_count increments by 8.
- Write to x0: A writes rd=0, data=10000. Required: a_ready=1, rf_we stays 0, drop_count=1, and rs1=0 reads rv1=0 even if rf_rv1 is nonzero.
- Forwarding: write rd=5, data=0xDEAD and set rs1=5 in the staging cycle while rf_rv1 still holds the old value 105. Required: rv1=0xDEAD in the staging cycle and from the RF in the following cycle.
- Hold: hold=1 for 3 cycles with both valid. Required: no ready, rf_we=0, and counters unchanged. On release, A is granted first.
- Mid-operation reset: pulse rst_n low between clock edges while a write is staged. Required: rf_we drops to 0 immediately, the RF location keeps its old value, and the counters read 0.
